// File: rtl/led_blink_pkg.sv
// -----------------------------------------------------------------------------
// led_blink_pkg
// Shared types and constants for the LED blink/timer bank.
//   mode_t              : per-channel operating mode (OFF/TOGGLE/PULSE/PWM)
//   CH_IDX_W            : width of the configuration channel index
//   DEFAULT_PERIOD_CFG  : reset period; short in SIMULATION builds so that
//                         waveforms stay readable, one second at 50 MHz otherwise
// Optional feature macro used by the bank: LED_BLINK_SYNC_EN.
// -----------------------------------------------------------------------------
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_PULSE  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_t;

  localparam int CH_IDX_W = 3;

`ifdef SIMULATION
  localparam int DEFAULT_PERIOD_CFG = 50;
`else
  localparam int DEFAULT_PERIOD_CFG = 50000000;
`endif

endpackage

// File: rtl/led_blink_channel.sv
// -----------------------------------------------------------------------------
// led_blink_channel
// One blink/timer channel: holds mode, period, duty and the running counter,
// and produces the registered LED bit and the one-cycle wrap strobe.
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   ce_i                 : shared clock enable from the bank prescaler
//   en_i                 : run enable for this channel
//   wr_i                 : decoded configuration write for this channel
//   mode_i/period_i/duty_i : configuration fields loaded on wr_i
//   sync_restart_i       : phase-align restart (only with LED_BLINK_SYNC_EN)
//   led_o, tick_o        : registered LED output and wrap strobe
// -----------------------------------------------------------------------------
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 50000000
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
`ifdef LED_BLINK_SYNC_EN
  input  logic             sync_restart_i,
`endif
  input  logic             ce_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             led_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_DUTY   = CNT_W'(DEFAULT_PERIOD / 2);

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] last_cnt;
  logic             step;
  logic             wrap;
  logic             restart;

  // Period 0 behaves as 1, so the last count value is 0 in both cases.
  assign last_cnt = (period_q == '0) ? '0 : period_q - CNT_W'(1);
  assign step     = ce_i & en_i;
  // ">=" rather than "==" so a counter left beyond a shrunk period wraps
  // on the next enabled step instead of running round the full range.
  assign wrap     = step & (cnt_q >= last_cnt);

`ifdef LED_BLINK_SYNC_EN
  assign restart = sync_restart_i;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    tick_d   = 1'b0;

    if (restart) begin
      // Phase alignment only; configuration and PWM level are kept.
      cnt_d = '0;
      if (mode_q != MODE_PWM) begin
        led_d = 1'b0;
      end
    end else if (wr_i) begin
      // A write always beats a coincident wrap: no tick, no toggle.
      mode_d   = mode_t'(mode_i);
      period_d = period_i;
      duty_d   = duty_i;
      cnt_d    = '0;
      led_d    = 1'b0;
    end else begin
      if (step) begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      tick_d = wrap & (mode_q != MODE_OFF);
      case (mode_q)
        MODE_OFF:    led_d = 1'b0;
        MODE_TOGGLE: led_d = led_q ^ wrap;
        MODE_PULSE:  led_d = wrap;
        MODE_PWM: begin
          // Compare against the next count so the LED lines up with it.
          if (en_i) begin
            led_d = (cnt_d < duty_q);
          end
        end
        default:     led_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      mode_q   <= MODE_TOGGLE;
      period_q <= RST_PERIOD;
      duty_q   <= RST_DUTY;
      cnt_q    <= '0;
      led_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
    end
  end

  assign led_o  = led_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/led_blink_bank.sv
// -----------------------------------------------------------------------------
// led_blink_bank
// Bank of NCH independent LED blink/timer channels sharing one clock-enable
// prescaler. Each channel is programmed at runtime with mode, period and duty.
// Ports:
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   sync_restart       : phase-align all channels (only with LED_BLINK_SYNC_EN)
//   en[NCH]            : per-channel run enable
//   cfg_we, cfg_ch     : single-cycle configuration write and target channel
//   cfg_mode/period/duty : configuration fields
//   led[NCH], tick[NCH]: registered LED bits and one-cycle wrap strobes
//   cfg_err            : one-cycle pulse after a write to a missing channel
// Optional feature macro: LED_BLINK_SYNC_EN (adds the sync_restart input).
// -----------------------------------------------------------------------------
module led_blink_bank
  import led_blink_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int CNT_W          = 26,
  parameter int PRESC          = 1,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_CFG
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
`ifdef LED_BLINK_SYNC_EN
  input  logic                sync_restart,
`endif
  input  logic [NCH-1:0]      en,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  output logic [NCH-1:0]      led,
  output logic [NCH-1:0]      tick,
  output logic                cfg_err
);

  localparam int PCNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESC - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              ce;
  logic              restart;
  logic              cfg_err_q, cfg_err_d;
  logic              ch_invalid;

`ifdef LED_BLINK_SYNC_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif

  // With PRESC=1 the counter is stuck at 0 == PCNT_LAST, so ce stays high.
  assign ce = (pcnt_q == PCNT_LAST);

  always_comb begin
    pcnt_d = pcnt_q + PCNT_W'(1);
    if (restart || ce) begin
      pcnt_d = '0;
    end
  end

  // One extra bit so NCH=8 does not alias to 0 in the comparison.
  assign ch_invalid = ({1'b0, cfg_ch} >= (CH_IDX_W + 1)'(NCH));
  assign cfg_err_d  = cfg_we & ~restart & ch_invalid;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pcnt_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic wr;
    assign wr = cfg_we & (cfg_ch == CH_IDX_W'(gi));

    led_blink_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_channel (
      .sys_clk_i      (sys_clk),
      .sys_rst_i      (sys_rst),
`ifdef LED_BLINK_SYNC_EN
      .sync_restart_i (sync_restart),
`endif
      .ce_i           (ce),
      .en_i           (en[gi]),
      .wr_i           (wr),
      .mode_i         (cfg_mode),
      .period_i       (cfg_period),
      .duty_i         (cfg_duty),
      .led_o          (led[gi]),
      .tick_o         (tick[gi])
    );
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// -----------------------------------------------------------------------------
// tb_led_blink_bank
// Directed bench for led_blink_bank. Two instances share every input: u0 with
// PRESC=1 and u3 with PRESC=3, both with DEFAULT_PERIOD=50 and NCH=4.
// Channel 3 is never reconfigured until the final reset, so its expected
// behaviour is a closed form of the edge count since reset release.
// Optional feature macro exercised when defined: LED_BLINK_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_led_blink_bank;

  localparam int NCH   = 4;
  localparam int CNT_W = 26;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             sync_restart;
  logic [NCH-1:0]   en;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic [NCH-1:0]   led0, tick0, led3, tick3;
  logic             err0, err3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nce    = 0;

  always #5 sys_clk = ~sys_clk;

  led_blink_bank #(.NCH(NCH), .CNT_W(CNT_W), .PRESC(1), .DEFAULT_PERIOD(50)) u0 (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
`ifdef LED_BLINK_SYNC_EN
    .sync_restart (sync_restart),
`endif
    .en           (en),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .led          (led0),
    .tick         (tick0),
    .cfg_err      (err0)
  );

  led_blink_bank #(.NCH(NCH), .CNT_W(CNT_W), .PRESC(3), .DEFAULT_PERIOD(50)) u3 (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
`ifdef LED_BLINK_SYNC_EN
    .sync_restart (sync_restart),
`endif
    .en           (en),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .led          (led3),
    .tick         (tick3),
    .cfg_err      (err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [1:0] mode,
                           input int period, input int duty);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = CNT_W'(period);
    cfg_duty   = CNT_W'(duty);
    step();
    cfg_we     = 1'b0;
    $display("cyc=%0d cfg write ch=%0d mode=%0d period=%0d duty=%0d",
             cyc, ch, mode, period, duty);
  endtask

  // Untouched channel 3 on u0: toggles every 50 edges after reset release.
  task automatic chk_ch3();
    chk("ch3_led", 32'(led0[3]), 32'(((cyc / 50) % 2) == 1));
    chk("ch3_tick", 32'(tick0[3]), 32'((cyc % 50) == 0 && cyc > 0));
  endtask

  initial begin
    sys_rst      = 1'b1;
    sync_restart = 1'b0;
    en           = '0;
    cfg_we       = 1'b0;
    cfg_ch       = '0;
    cfg_mode     = '0;
    cfg_period   = '0;
    cfg_duty     = '0;

    // ---------------- reset state ----------------
    repeat (3) step();
    chk("rst_led", 32'(led0), 32'h0);
    chk("rst_tick", 32'(tick0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    chk("rst_led_p3", 32'(led3), 32'h0);
    sys_rst = 1'b0;
    en      = 4'hF;
    cyc     = 0;

    // ---------------- default TOGGLE, period 50 ----------------
    for (int k = 1; k <= 200; k++) begin
      step();
      chk("dflt_led", 32'(led0), ((cyc / 50) % 2) == 1 ? 32'hF : 32'h0);
      chk("dflt_tick", 32'(tick0), (cyc % 50) == 0 ? 32'hF : 32'h0);
      chk("dflt_tick_p3", 32'(tick3), (cyc == 150) ? 32'hF : 32'h0);
      chk("dflt_led_p3", 32'(led3), (cyc >= 150) ? 32'hF : 32'h0);
    end
    $display("cyc=%0d default toggle phase done", cyc);

    // ---------------- PWM on ch1 ----------------
    cfg_write(3'd1, 2'd3, 10, 3);
    chk("pwm_wr_led", 32'(led0[1]), 32'h0);
    chk("pwm_wr_tick", 32'(tick0[1]), 32'h0);
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("pwm3_led", 32'(led0[1]), 32'((j % 10) < 3));
      chk("pwm3_tick", 32'(tick0[1]), 32'((j % 10) == 0));
      chk_ch3();
    end
    cfg_write(3'd1, 2'd3, 10, 0);
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("pwm0_led", 32'(led0[1]), 32'h0);
    end
    cfg_write(3'd1, 2'd3, 10, 12);
    chk("pwm12_wr_led", 32'(led0[1]), 32'h0);
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("pwm12_led", 32'(led0[1]), 32'h1);
    end

    // ---------------- PULSE on ch2 with PRESC=3 (u3) ----------------
    cfg_write(3'd2, 2'd2, 4, 0);
    chk("pls_wr_tick_p3", 32'(tick3[2]), 32'h0);
    chk("pls_wr_led_p3", 32'(led3[2]), 32'h0);
    nce = 0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if ((cyc % 3) == 0) nce++;
      chk("pls4_tick_p3", 32'(tick3[2]), 32'((cyc % 3) == 0 && (nce % 4) == 0));
      chk("pls4_led_p3", 32'(led3[2]), 32'((cyc % 3) == 0 && (nce % 4) == 0));
      chk("pls4_tick_p1", 32'(tick0[2]), 32'((j % 4) == 0));
    end
    cfg_write(3'd2, 2'd2, 0, 0);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("pls0_tick_p3", 32'(tick3[2]), 32'((cyc % 3) == 0));
      chk("pls0_led_p3", 32'(led3[2]), 32'((cyc % 3) == 0));
    end

    // ---------------- write to missing channel 6 (aliases ch2 if truncated) ----------------
    cfg_write(3'd6, 2'd0, 1, 0);
    chk("err_pulse", 32'(err0), 32'h1);
    chk("err_pulse_p3", 32'(err3), 32'h1);
    chk("err_ch1_held", 32'(led0[1]), 32'h1);
    chk("err_ch2_held", 32'(led0[2]), 32'h1);
    chk_ch3();
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("err_clear", 32'(err0), 32'h0);
      chk("err_ch2_tick", 32'(tick0[2]), 32'h1);
      chk("err_ch1_held", 32'(led0[1]), 32'h1);
      chk_ch3();
    end

    // ---------------- en pause on ch0, TOGGLE period 5 ----------------
    cfg_write(3'd0, 2'd1, 5, 0);
    chk("pause_wr_led", 32'(led0[0]), 32'h0);
    for (int j = 1; j <= 21; j++) begin
      if (j == 8)  en[0] = 1'b0;
      if (j == 15) en[0] = 1'b1;
      step();
      chk("pause_led", 32'(led0[0]), 32'(j >= 5 && j < 17));
      chk("pause_tick", 32'(tick0[0]), 32'(j == 5 || j == 17));
    end
    // Next wrap of ch0 falls on this write edge; the write must win.
    cfg_write(3'd0, 2'd1, 5, 0);
    chk("coll_tick", 32'(tick0[0]), 32'h0);
    chk("coll_led", 32'(led0[0]), 32'h0);
    for (int j = 1; j <= 5; j++) begin
      step();
      chk("coll_after_tick", 32'(tick0[0]), 32'(j == 5));
      chk("coll_after_led", 32'(led0[0]), 32'(j == 5));
    end

`ifdef LED_BLINK_SYNC_EN
    // ---------------- sync_restart ----------------
    cfg_write(3'd0, 2'd2, 7, 0);
    cfg_write(3'd1, 2'd2, 11, 0);
    repeat (3) step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    $display("cyc=%0d sync_restart pulse", cyc);
    chk("sync_led", 32'(led0[1:0]), 32'h0);
    chk("sync_tick", 32'(tick0[1:0]), 32'h0);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("sync_tick0", 32'(tick0[0]), 32'(j == 7));
      chk("sync_tick1", 32'(tick0[1]), 32'(j == 11));
      chk("sync_led1", 32'(led0[1]), 32'(j == 11));
    end
    sync_restart = 1'b1;
`endif

    // ---------------- reset mid-operation with a concurrent write ----------------
    sys_rst    = 1'b1;
    cfg_we     = 1'b1;
    cfg_ch     = 3'd0;
    cfg_mode   = 2'd0;
    cfg_period = CNT_W'(3);
    step();
    sys_rst      = 1'b0;
    cfg_we       = 1'b0;
    sync_restart = 1'b0;
    cyc          = 0;
    $display("cyc=%0d mid-operation reset", cyc);
    chk("mrst_led", 32'(led0), 32'h0);
    chk("mrst_tick", 32'(tick0), 32'h0);
    chk("mrst_err", 32'(err0), 32'h0);
    for (int k = 1; k <= 51; k++) begin
      step();
      chk("mrst_led_run", 32'(led0), (cyc >= 50) ? 32'hF : 32'h0);
      chk("mrst_tick_run", 32'(tick0), (cyc == 50) ? 32'hF : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
